// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmit path.
// Line-state encoding and default timing shared with the receive side.
package uart_tx_buffered_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;
  localparam int DATA_BITS    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART shifter.
// First-word-fall-through: dout shows the head entry whenever non-empty.
module uart_tx_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // a pop in the same cycle frees the slot a full write needs
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by edge-detected byte strobes.
// A small FIFO absorbs bursts; frames run back to back.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           busy_q;
  logic           ovf_q;
  logic           tx_ready_d;

  logic           accept;
  logic           wr_en;
  logic           pop;
  logic           baud_end;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  cnt_nxt;

  assign accept   = tx_ready & ~tx_ready_d;
  assign wr_en    = accept & (~fifo_full | pop);
  assign cnt_nxt  = fifo_count + CW'(wr_en) - CW'(pop);
  assign baud_end = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // chain straight into the next start bit
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // line level follows the next state so the pin comes from a flop
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_ready_d <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= (state_d != S_IDLE) | (cnt_nxt != '0);
      ovf_q      <= ovf_q | (accept & fifo_full & ~pop);
      tx_ready_d <= tx_ready;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered.
// Short bit period keeps every scenario quick.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd;
  logic       busy;
  logic       full;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reset();
    rst = 1'b0;
    tx_ready = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input int hi, input int lo);
    tx_data = d;
    tx_ready = 1'b1;
    repeat (hi) @(negedge clk);
    tx_ready = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // mid-bit sampling receiver; t0 = cycle of first low sample
  task automatic rx_frame(output logic [7:0] b, output int t0,
                          output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    b = '0;
    t0 = 0;
    while (txd !== 1'b0) begin
      if (n == 40 * CPB) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txd;
    end
    repeat (CPB) @(negedge clk);
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic watch_idle(input int n, output bit seen_low);
    seen_low = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL rst_txd: got %b want 1", txd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL rst_full: got %b want 0", full);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf: got %b want 0", overflow);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, busy} !== 2'b10) begin
      errors++;
      $display("FAIL post_rst_idle: got %b want 10", {txd, busy});
    end
  endtask

  task automatic test_single();
    logic [9:0] frm;
    int bad;
    apply_reset();
    frm = {1'b1, 8'h55, 1'b0};
    bad = 0;
    tx_data = 8'h55;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if ({txd, busy} !== 2'b11) begin
      errors++;
      $display("FAIL single_queued: got %b want 11", {txd, busy});
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL single_start_lat: got %b want 0", txd);
    end
    for (int i = 0; i < FRAME; i++) begin
      if (txd !== frm[i / CPB]) bad++;
      if (i == FRAME - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_stop: got %b want 1", busy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wave: got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({txd, busy} !== 2'b10) begin
      errors++;
      $display("FAIL single_end: got %b want 10", {txd, busy});
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [4];
    logic [7:0] got [4];
    int t [4];
    bit ok [4];
    exp[0] = 8'h00;
    exp[1] = 8'h0B;
    exp[2] = 8'h00;
    exp[3] = 8'h05;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) push(exp[i], 2, 1);
      end
      begin
        for (int i = 0; i < 4; i++) rx_frame(got[i], t[i], ok[i]);
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!ok[i] || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL burst_byte%0d: got %h ok=%0d want %h",
                 i, got[i], ok[i], exp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (t[i+1] - t[i] != FRAME) begin
        errors++;
        $display("FAIL burst_gap%0d: got %0d want %0d",
                 i, t[i+1] - t[i], FRAME);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_level_held();
    logic [7:0] got;
    int t0;
    bit ok;
    bit rep;
    apply_reset();
    rep = 1'b0;
    fork
      begin
        tx_data = 8'h73;
        tx_ready = 1'b1;
        repeat (30 * CPB) @(negedge clk);
        tx_ready = 1'b0;
      end
      begin
        rx_frame(got, t0, ok);
        watch_idle(25 * CPB, rep);
      end
    join
    checks++;
    if (!ok || got !== 8'h73) begin
      errors++;
      $display("FAIL level_byte: got %h ok=%0d want 73", got, ok);
    end
    checks++;
    if (rep || busy !== 1'b0) begin
      errors++;
      $display("FAIL level_repeat: got rep=%0d busy=%b want 0 0",
               rep, busy);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got [5];
    int t [5];
    bit ok [5];
    bit low;
    logic [7:0] v;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = 8'hA0 + 8'(i);
          push(v, 1, 1);
        end
        checks++;
        if ({full, overflow, busy} !== 3'b111) begin
          errors++;
          $display("FAIL ovf_flags: got %b want 111",
                   {full, overflow, busy});
        end
      end
      begin
        for (int i = 0; i < 5; i++) rx_frame(got[i], t[i], ok[i]);
      end
    join
    for (int i = 0; i < 5; i++) begin
      v = 8'hA0 + 8'(i);
      checks++;
      if (!ok[i] || got[i] !== v) begin
        errors++;
        $display("FAIL ovf_byte%0d: got %h ok=%0d want %h",
                 i, got[i], ok[i], v);
      end
    end
    watch_idle(12 * CPB, low);
    checks++;
    if (low) begin
      errors++;
      $display("FAIL ovf_extra_frame: got low=1 want 0");
    end
    checks++;
    if ({overflow, full} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 10", {overflow, full});
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0] got;
    logic [7:0] v;
    int t0;
    int n;
    bit ok;
    apply_reset();
    push(8'hB0, 1, 1);
    n = 0;
    while (txd !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    for (int i = 1; i < 5; i++) begin
      v = 8'hB0 + 8'(i);
      push(v, 1, 1);
    end
    while (cyc < t0 + FRAME - 1) @(negedge clk);
    checks++;
    if (cyc != t0 + FRAME - 1 || full !== 1'b1) begin
      errors++;
      $display("FAIL pop_setup: got cyc=%0d full=%b want %0d 1",
               cyc, full, t0 + FRAME - 1);
    end
    tx_data = 8'hB5;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if ({overflow, full, txd} !== 3'b010) begin
      errors++;
      $display("FAIL pop_push_flags: got %b want 010",
               {overflow, full, txd});
    end
    for (int i = 1; i < 6; i++) begin
      v = 8'hB0 + 8'(i);
      rx_frame(got, t0, ok);
      checks++;
      if (!ok || got !== v) begin
        errors++;
        $display("FAIL pop_byte%0d: got %h ok=%0d want %h",
                 i, got, ok, v);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL pop_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    int t0;
    int n;
    bit ok;
    bit low;
    apply_reset();
    push(8'h0A, 1, 1);
    n = 0;
    while (txd !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    push(8'h11, 1, 1);
    push(8'h22, 1, 1);
    while (cyc < t0 + 4 * CPB + CPB / 2) @(negedge clk);
    checks++;
    if ({txd, busy} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_bit3: got %b want 11", {txd, busy});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({txd, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_async: got %b want 1000",
               {txd, busy, full, overflow});
    end
    @(negedge clk);
    rst = 1'b1;
    watch_idle(12 * CPB, low);
    checks++;
    if (low || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got low=%0d busy=%b want 0 0",
               low, busy);
    end
    fork
      push(8'h3C, 1, 1);
      rx_frame(got, t0, ok);
    join
    checks++;
    if (!ok || got !== 8'h3C) begin
      errors++;
      $display("FAIL midrst_new: got %h ok=%0d want 3c", got, ok);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_level_held();
    test_overflow();
    test_push_on_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
